// File: rtl/mac_stream.sv
// Streaming multiply-accumulate: two skew-buffered operand streams are paired in arrival order,
// multiplied, and summed in groups of LEN products; each group emits one result pulse.
module mac_stream #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned LEN    = 10,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ACC_W  = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in_a,
  input  logic                       in_valid_a,
  output logic                       in_ready_a,
  input  logic [DATA_W-1:0]          in_b,
  input  logic                       in_valid_b,
  output logic                       in_ready_b,
  input  logic                       is_signed,
  output logic [ACC_W-1:0]           mac_out,
  output logic                       out_valid,
  output logic [$clog2(LEN+1)-1:0]   group_cnt,
  output logic                       drop_err
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW  = $clog2(DEPTH + 1);
  localparam int unsigned CW  = $clog2(LEN + 1);
  localparam int unsigned PRW = 2 * DATA_W;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [DATA_W-1:0] mem_a_q [DEPTH];
  logic [DATA_W-1:0] mem_b_q [DEPTH];
  logic [PW-1:0]     wr_a_q, rd_a_q, wr_b_q, rd_b_q;
  logic [SW-1:0]     cnt_a_q, cnt_b_q;
  logic              push_a, push_b, fire;

  logic [PRW-1:0]    a_ext, b_ext, prod;
  logic [PRW-1:0]    p_q;
  logic              p_sgn_q, p_vld_q;
  logic [ACC_W-1:0]  p_ext, acc_q, acc_sum;
  logic [CW-1:0]     group_cnt_q;
  logic [ACC_W-1:0]  mac_out_q;
  logic              out_valid_q, drop_err_q;
  logic              last;

  // Ready looks only at the registered count so a same-cycle pop never widens acceptance.
  assign in_ready_a = (cnt_a_q < SW'(DEPTH));
  assign in_ready_b = (cnt_b_q < SW'(DEPTH));
  assign push_a     = in_valid_a & in_ready_a;
  assign push_b     = in_valid_b & in_ready_b;
  assign fire       = (cnt_a_q != '0) & (cnt_b_q != '0);

  always_ff @(posedge clk) begin
    if (push_a) mem_a_q[wr_a_q] <= in_a;
    if (push_b) mem_b_q[wr_b_q] <= in_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_a_q  <= '0;
      rd_a_q  <= '0;
      cnt_a_q <= '0;
      wr_b_q  <= '0;
      rd_b_q  <= '0;
      cnt_b_q <= '0;
    end else begin
      if (push_a) wr_a_q <= ptr_inc(wr_a_q);
      if (push_b) wr_b_q <= ptr_inc(wr_b_q);
      if (fire) begin
        rd_a_q <= ptr_inc(rd_a_q);
        rd_b_q <= ptr_inc(rd_b_q);
      end
      if (push_a && !fire)      cnt_a_q <= cnt_a_q + 1'b1;
      else if (!push_a && fire) cnt_a_q <= cnt_a_q - 1'b1;
      if (push_b && !fire)      cnt_b_q <= cnt_b_q + 1'b1;
      else if (!push_b && fire) cnt_b_q <= cnt_b_q - 1'b1;
    end
  end

  always_comb begin
    a_ext = {{DATA_W{is_signed & mem_a_q[rd_a_q][DATA_W-1]}}, mem_a_q[rd_a_q]};
    b_ext = {{DATA_W{is_signed & mem_b_q[rd_b_q][DATA_W-1]}}, mem_b_q[rd_b_q]};
    // Low 2*DATA_W bits of the product are exact for both signed and unsigned operands.
    prod  = a_ext * b_ext;
  end

  always_comb begin
    if (p_sgn_q) p_ext = ACC_W'($signed(p_q));
    else         p_ext = ACC_W'(p_q);
    acc_sum = acc_q + p_ext;
    last    = (group_cnt_q == CW'(LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q         <= '0;
      p_sgn_q     <= 1'b0;
      p_vld_q     <= 1'b0;
      acc_q       <= '0;
      group_cnt_q <= '0;
      mac_out_q   <= '0;
      out_valid_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      p_vld_q     <= fire;
      if (fire) begin
        p_q     <= prod;
        p_sgn_q <= is_signed;
      end
      if (p_vld_q) begin
        if (last) begin
          mac_out_q   <= acc_sum;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          group_cnt_q <= '0;
        end else begin
          acc_q       <= acc_sum;
          group_cnt_q <= group_cnt_q + 1'b1;
        end
      end
      if ((in_valid_a && !in_ready_a) || (in_valid_b && !in_ready_b)) drop_err_q <= 1'b1;
    end
  end

  assign mac_out   = mac_out_q;
  assign out_valid = out_valid_q;
  assign group_cnt = group_cnt_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_mac_stream.sv
// Self-checking bench for mac_stream: queue-based reference model compared every cycle,
// directed scenarios with literal expected results, then a randomized soak.
module tb_mac_stream;
  localparam int DATA_W = 4;
  localparam int LEN    = 10;
  localparam int DEPTH  = 4;
  localparam int ACC_W  = 12;
  localparam int CW     = $clog2(LEN + 1);
  localparam int MASK   = (1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] in_a = '0, in_b = '0;
  logic              in_valid_a = 1'b0, in_valid_b = 1'b0, is_signed = 1'b0;
  logic              in_ready_a, in_ready_b, out_valid, drop_err;
  logic [ACC_W-1:0]  mac_out;
  logic [CW-1:0]     group_cnt;

  always #5 clk = ~clk;

  mac_stream #(.DATA_W(DATA_W), .LEN(LEN), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset),
    .in_a(in_a), .in_valid_a(in_valid_a), .in_ready_a(in_ready_a),
    .in_b(in_b), .in_valid_b(in_valid_b), .in_ready_b(in_ready_b),
    .is_signed(is_signed), .mac_out(mac_out), .out_valid(out_valid),
    .group_cnt(group_cnt), .drop_err(drop_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: operand queues, one pending product, running integer sum.
  int  qa[$], qb[$];
  bit  pend_v = 0;
  int  pend_p = 0, acc = 0, cnt = 0, exp_mac = 0;
  bit  exp_ov = 0, exp_drop = 0;
  bit  m_ra, m_rb, m_fire;
  int  ma, mb;
  int  cyc = 0;
  bit  chk_en = 0;
  int  pulse_cyc[$], pulse_val[$];

  function automatic int sval(input int raw, input bit sgn);
    return (sgn && raw >= (1 << (DATA_W - 1))) ? raw - (1 << DATA_W) : raw;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      qa.delete();
      qb.delete();
      pend_v = 0; acc = 0; cnt = 0; exp_mac = 0; exp_ov = 0; exp_drop = 0;
    end else begin
      m_ra   = qa.size() < DEPTH;
      m_rb   = qb.size() < DEPTH;
      m_fire = qa.size() > 0 && qb.size() > 0;
      exp_ov = 0;
      if (pend_v) begin
        acc += pend_p;
        cnt++;
        if (cnt == LEN) begin
          exp_mac = acc & MASK;
          exp_ov  = 1;
          acc     = 0;
          cnt     = 0;
        end
      end
      pend_v = m_fire;
      if (m_fire) begin
        ma = qa.pop_front();
        mb = qb.pop_front();
        pend_p = sval(ma, is_signed) * sval(mb, is_signed);
      end
      if (in_valid_a) begin
        if (m_ra) qa.push_back(int'(in_a));
        else      exp_drop = 1;
      end
      if (in_valid_b) begin
        if (m_rb) qb.push_back(int'(in_b));
        else      exp_drop = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mac_out", 64'(mac_out), 64'(exp_mac));
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      check("group_cnt", 64'(group_cnt), 64'(cnt));
      check("in_ready_a", 64'(in_ready_a), 64'(qa.size() < DEPTH));
      check("in_ready_b", 64'(in_ready_b), 64'(qb.size() < DEPTH));
      check("drop_err", 64'(drop_err), 64'(exp_drop));
      if (out_valid === 1'b1) begin
        pulse_cyc.push_back(cyc);
        pulse_val.push_back(int'(mac_out));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_mac_out", 64'(mac_out), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ready_a", 64'(in_ready_a), 64'd1);
    check("rst_ready_b", 64'(in_ready_b), 64'd1);
    check("rst_group_cnt", 64'(group_cnt), 64'd0);
    check("rst_drop_err", 64'(drop_err), 64'd0);
  endtask

  task automatic drive_pairs(input int n, input int a, input int b, input bit sgn);
    for (int i = 0; i < n; i++) begin
      in_a = DATA_W'(a); in_b = DATA_W'(b); is_signed = sgn;
      in_valid_a = 1'b1; in_valid_b = 1'b1;
      step();
    end
    in_valid_a = 1'b0; in_valid_b = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int bound);
    int k = 0;
    while (pulse_cyc.size() < n && k < bound) begin
      step();
      k++;
    end
    check("pulse_count", 64'(pulse_cyc.size()), 64'(n));
  endtask

  task automatic clear_log();
    pulse_cyc.delete();
    pulse_val.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    step();
    step();
    reset = 1'b0;
    chk_en = 1;

    // Unsigned full scale and pulse latency.
    do_reset();
    check_reset_vals();
    clear_log();
    drive_pairs(10, 15, 15, 1'b0);
    e0 = cyc;
    wait_pulses(1, 20);
    check("full_scale_val", 64'(pulse_val[0]), 64'd2250);
    check("pulse_latency", 64'(pulse_cyc[0] - e0), 64'd2);
    repeat (3) step();
    check("single_pulse", 64'(pulse_cyc.size()), 64'd1);
    check("group_cnt_back", 64'(group_cnt), 64'd0);

    // Signed then unsigned interpretation of the same bits.
    do_reset();
    clear_log();
    drive_pairs(10, 8, 7, 1'b1);
    wait_pulses(1, 20);
    check("signed_val", 64'(pulse_val[0]), 64'h0DD0);
    clear_log();
    drive_pairs(10, 8, 7, 1'b0);
    wait_pulses(1, 20);
    check("unsigned_val", 64'(pulse_val[0]), 64'd560);

    // Skewed arrival: A leads B by four operands.
    do_reset();
    clear_log();
    is_signed = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_a = DATA_W'(i); in_valid_a = 1'b1;
      step();
    end
    in_valid_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_b = DATA_W'(1); in_valid_b = 1'b1;
      step();
    end
    in_valid_b = 1'b0;
    drive_pairs(6, 1, 1, 1'b0);
    wait_pulses(1, 20);
    check("skew_val", 64'(pulse_val[0]), 64'd16);
    check("skew_no_drop", 64'(drop_err), 64'd0);

    // Overflow of the A buffer.
    do_reset();
    in_a = 4'd3; in_valid_a = 1'b1;
    repeat (4) step();
    check("ovf_ready_low", 64'(in_ready_a), 64'd0);
    step();
    in_valid_a = 1'b0;
    check("ovf_drop_set", 64'(drop_err), 64'd1);
    in_b = 4'd2; in_valid_b = 1'b1;
    step();
    check("ovf_ready_before_pop", 64'(in_ready_a), 64'd0);
    step();
    check("ovf_ready_after_pop", 64'(in_ready_a), 64'd1);
    repeat (2) step();
    in_valid_b = 1'b0;
    repeat (4) step();
    check("ovf_drop_sticky", 64'(drop_err), 64'd1);
    check("ovf_group_cnt", 64'(group_cnt), 64'd4);

    // Back-to-back groups.
    do_reset();
    clear_log();
    drive_pairs(30, 15, 15, 1'b0);
    wait_pulses(3, 20);
    check("b2b_gap1", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd10);
    check("b2b_gap2", 64'(pulse_cyc[2] - pulse_cyc[1]), 64'd10);
    for (int i = 0; i < 3; i++) check("b2b_val", 64'(pulse_val[i]), 64'd2250);

    // Reset in the middle of a group.
    drive_pairs(6, 15, 15, 1'b0);
    step();
    do_reset();
    check_reset_vals();
    clear_log();
    repeat (5) step();
    check("no_partial_pulse", 64'(pulse_cyc.size()), 64'd0);
    drive_pairs(10, 1, 1, 1'b0);
    wait_pulses(1, 20);
    check("post_reset_val", 64'(pulse_val[0]), 64'd10);

    // Randomized soak with occasional resets; the compare process does the checking.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid_a = ($urandom_range(0, 9) < 7);
      in_valid_b = ($urandom_range(0, 9) < 7);
      in_a       = DATA_W'($urandom);
      in_b       = DATA_W'($urandom);
      is_signed  = $urandom_range(0, 1) == 1;
      reset      = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
